// File: rtl/key_debounce.sv
// Pushbutton synchroniser + debouncer: clean level, 1-cycle press and release pulses.
// Optional auto-repeat of btn_press while held is built when AUTOREPEAT_EN is defined.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1,
  parameter int CNT_W           = 26,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic CLOCK_50,
  input  logic KEY,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  typedef enum logic [1:0] {IDLE, CHK_PRESS, HELD, CHK_REL} state_t;

  localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int CNT_LIMIT = (REPEAT_DELAY > DEBOUNCE_CYCLES) ? REPEAT_DELAY : DEBOUNCE_CYCLES;

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      (CNT_W < 31 && (1 << CNT_W) <= CNT_LIMIT)) begin : g_bad_cfg
    $error("key_debounce: invalid parameter combination");
  end

  logic [1:0]       sync;
  logic             s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, press_nxt, release_nxt;

  // Polarity is normalised after the synchroniser so the FSM only ever sees s=1 as pressed.
  always_ff @(posedge CLOCK_50) begin
    if (KEY) sync <= {2{RELEASED_RAW}};
    else     sync <= {sync[0], btn_raw};
  end

  assign s = (ACTIVE_LOW != 0) ? ~sync[1] : sync[1];

`ifdef AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  logic [CNT_W-1:0] rcnt, rcnt_nxt;
  logic             rep_phase, rep_phase_nxt;

  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      rcnt      <= '0;
      rep_phase <= 1'b0;
    end else begin
      rcnt      <= rcnt_nxt;
      rep_phase <= rep_phase_nxt;
    end
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
`ifdef AUTOREPEAT_EN
    rcnt_nxt      = rcnt;
    rep_phase_nxt = rep_phase;
`endif
    case (state)
      IDLE: begin
`ifdef AUTOREPEAT_EN
        rcnt_nxt      = '0;
        rep_phase_nxt = 1'b0;
`endif
        if (s) begin
          state_nxt = CHK_PRESS;
          cnt_nxt   = '0;
        end
      end
      CHK_PRESS: begin
        if (!s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_nxt = CHK_REL;
          cnt_nxt   = '0;
        end
`ifdef AUTOREPEAT_EN
        // First repeat waits the long delay, later ones the short period.
        else if (rcnt == (rep_phase ? PERIOD_LAST : DELAY_LAST)) begin
          press_nxt     = 1'b1;
          rcnt_nxt      = '0;
          rep_phase_nxt = 1'b1;
        end else begin
          rcnt_nxt = rcnt + 1'b1;
        end
`endif
      end
      CHK_REL: begin
        if (s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
`ifdef AUTOREPEAT_EN
          rcnt_nxt      = '0;
          rep_phase_nxt = 1'b0;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: active-low and active-high instances driven with the same button
// activity and checked each cycle against a run-length reference model, plus directed scenarios.
module tb_key_debounce;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic key = 1'b1;
  logic pressed = 1'b0;
  logic raw_a, raw_b;
  logic level_a, press_a, release_a;
  logic level_b, press_b, release_b;

  assign raw_a = ~pressed;
  assign raw_b = pressed;

  always #5 clk = ~clk;

  key_debounce #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1), .CNT_W(8),
                 .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_a (
    .CLOCK_50(clk), .KEY(key), .btn_raw(raw_a),
    .btn_level(level_a), .btn_press(press_a), .btn_release(release_a));

  key_debounce #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0), .CNT_W(8),
                 .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_b (
    .CLOCK_50(clk), .KEY(key), .btn_raw(raw_b),
    .btn_level(level_b), .btn_press(press_b), .btn_release(release_b));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the pressed state seen two edges late; the opposite level is accepted once it
  // has been observed for D+1 consecutive edges. Repeats fire at RD, RD+RP, ... held edges.
  logic h0, h1, m_level, m_press, m_rel;
  int   run, hcnt;

  task automatic model_edge(input logic k, input logic p);
    logic smp;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (k) begin
      h0 = 1'b0; h1 = 1'b0; m_level = 1'b0; run = 0; hcnt = 0;
    end else begin
      smp = h1;
      h1  = h0;
      h0  = p;
`ifdef AUTOREPEAT_EN
      if (m_level && run == 0 && smp) begin
        hcnt++;
        if (hcnt >= RD && (hcnt - RD) % RP == 0) m_press = 1'b1;
      end
`endif
      if (smp != m_level) begin
        run++;
        if (run == D + 1) begin
          m_level = smp;
          m_press = smp;
          m_rel   = !smp;
          run     = 0;
          if (!smp) hcnt = 0;
        end
      end else begin
        run = 0;
      end
    end
  endtask

  int n_press, n_rel;

  task automatic step(input logic k, input logic p);
    key = k;
    pressed = p;
    @(posedge clk);
    model_edge(k, p);
    #1;
    chk("level_al", level_a, m_level);
    chk("press_al", press_a, m_press);
    chk("release_al", release_a, m_rel);
    chk("level_ah", level_b, m_level);
    chk("press_ah", press_b, m_press);
    chk("release_ah", release_b, m_rel);
    if (press_a) n_press++;
    if (release_a) n_rel++;
  endtask

  initial begin
    int first;
    int exp_rep;
    h0 = 1'b0; h1 = 1'b0; m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
    run = 0; hcnt = 0; n_press = 0; n_rel = 0;

    // 1: reset, clean press, clean release
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1);
      if (press_a && first == 0) first = i;
    end
    chk("s1_press_edge", first, 7);
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0);
      if (release_a && first == 0) first = i;
    end
    chk("s1_release_edge", first, 7);

    // 2: bouncing for 12 edges, then a clean hold
    n_press = 0;
    for (int i = 0; i < 12; i++) step(1'b0, ((i / 2) % 2) == 0);
    chk("s2_no_pulse_bounce", n_press, 0);
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1);
      if (press_a && first == 0) first = i;
    end
    chk("s2_press_edge", first, 7);
    chk("s2_press_count", n_press, 1);

    // 3: short release glitch while held
    n_press = 0; n_rel = 0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk("s3_level_kept", level_a, 1);
    chk("s3_no_release", n_rel, 0);
    chk("s3_no_press", n_press, 0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

    // 4: reset while held, then re-detect
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("s4_held", level_a, 1);
    n_rel = 0;
    step(1'b1, 1'b1);
    chk("s4_level_cleared", level_a, 0);
    chk("s4_no_release", n_rel, 0);
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1);
      if (press_a && first == 0) first = i;
    end
    chk("s4_repress_edge", first, 7);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

    // 5: long hold (repeats only with the auto-repeat build)
`ifdef AUTOREPEAT_EN
    exp_rep = 9;
`else
    exp_rep = 1;
`endif
    n_press = 0;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
    chk("s5_press_count", n_press, exp_rep);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);

    // random runs of mixed length with occasional resets
    for (int seg = 0; seg < 400; seg++) begin
      logic p;
      int   len;
      p   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 199) == 0) step(1'b1, p);
        else step(1'b0, p);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
